// File: rtl/uart_hex_formatter_pkg.sv
// uart_hex_formatter_pkg: shared states, ASCII constants and nibble-to-hex conversion
package uart_hex_formatter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;
  localparam logic [7:0] ASCII_0 = "0";
  localparam logic [7:0] ASCII_UA = "A";
  localparam logic [7:0] ASCII_LA = "a";
  function automatic logic [7:0] hex2ascii(input logic [3:0] nibble, input logic uppercase);
    logic [7:0] v;
    v = {4'h0, nibble};
    return (v < 8'd10) ? ASCII_0 + v : (uppercase ? ASCII_UA : ASCII_LA) + v - 8'd10;
  endfunction
endpackage

// File: rtl/uart_hex_formatter_rom.sv
// hex_format_rom: format string as a byte ROM with registered read, index 0 = leftmost character
module hex_format_rom
  import uart_hex_formatter_pkg::*;
#(
  parameter int STR_LEN = 12,
  parameter int AW = 4,
  parameter logic [8*STR_LEN-1:0] FORMAT_STRING = "Btn \1 Sw \2\r\n"
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [7:0]    data
);
  logic [7:0] mem [2**AW];
  for (genvar i = 0; i < 2**AW; i++) begin : g_mem
    if (i < STR_LEN) begin : g_used
      assign mem[i] = FORMAT_STRING[8*(STR_LEN-1-i) +: 8];
    end else begin : g_pad
      assign mem[i] = 8'h00;
    end
  end
  always_ff @(posedge clk) data <= mem[addr];
endmodule

// File: rtl/uart_hex_formatter.sv
// uart_hex_formatter: walks a format string, expanding slot-marker bytes into hex digits of snapshotted din
module uart_hex_formatter
  import uart_hex_formatter_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int DIGITS_PER_SLOT = 2,
  parameter int STR_LEN = 12,
  parameter logic [8*STR_LEN-1:0] FORMAT_STRING = "Btn \1 Sw \2\r\n",
  parameter bit UPPERCASE = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [4*DIGITS_PER_SLOT*NUM_SLOTS-1:0] din,
  output logic [7:0]                             out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic                                   done
);
  localparam int D = DIGITS_PER_SLOT;
  localparam int DW = D > 1 ? $clog2(D) : 1;
  localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  localparam int IW = STR_LEN > 1 ? $clog2(STR_LEN) : 1;
  localparam int DINW = 4*D*NUM_SLOTS;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [SW-1:0] slot, slot_n;
  logic [DW-1:0] dig, dig_n;
  logic [DINW-1:0] snap, snap_n;
  logic [7:0] rom_data, data_n;
  logic ph, ph_n, done_n, is_ph, load_hex, load_lit;
  hex_format_rom #(.STR_LEN(STR_LEN), .AW(IW), .FORMAT_STRING(FORMAT_STRING)) u_rom (
    .clk(clk), .addr(idx_n), .data(rom_data)
  );
  assign is_ph = rom_data != 8'h00 && rom_data <= 8'(NUM_SLOTS);
  assign out_valid = state == S_SEND;
  assign busy = state != S_IDLE;
  always_comb begin
    state_n = state;
    idx_n = idx;
    slot_n = slot;
    dig_n = dig;
    ph_n = ph;
    snap_n = snap;
    done_n = 1'b0;
    load_hex = 1'b0;
    load_lit = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        snap_n = din;
        idx_n = '0;
        state_n = S_FETCH;
      end
      S_FETCH: begin
        state_n = S_SEND;
        ph_n = is_ph;
        slot_n = is_ph ? SW'(rom_data - 8'd1) : slot;
        dig_n = is_ph ? DW'(D-1) : dig;
        load_hex = is_ph;
        load_lit = !is_ph;
      end
      S_SEND: if (out_ready) begin
        if (ph && dig != '0) begin
          dig_n = dig - 1'b1;
          load_hex = 1'b1;
        end else if (idx == IW'(STR_LEN-1)) begin
          state_n = S_IDLE;
          done_n = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
    data_n = load_hex ? hex2ascii(snap[4*(int'(slot_n)*D + int'(dig_n)) +: 4], UPPERCASE)
           : load_lit ? rom_data : out_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      slot <= '0;
      dig <= '0;
      ph <= 1'b0;
      snap <= '0;
      out_data <= 8'h00;
      done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      slot <= slot_n;
      dig <= dig_n;
      ph <= ph_n;
      snap <= snap_n;
      out_data <= data_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_hex_formatter.sv
// tb_uart_hex_formatter: directed checks of message content, timing, back-pressure, start/reset handling
module tb_uart_hex_formatter;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [15:0] din = 16'h3A5F;
  logic [7:0] out_data;
  logic out_valid, busy, done;
  logic start2 = 1'b0, out_ready2 = 1'b1;
  logic [15:0] din2 = 16'hBEEF;
  logic [7:0] out_data2;
  logic out_valid2, busy2, done2;
  int n_cmp = 0, n_bad = 0;
  string msg = "Btn 5F Sw 3A\r\n";
  // {valid, data} per cycle after start for "\1\0\2\n" with din 0xBEEF, lowercase
  logic [8:0] tbl2 [12] = '{9'h000, 9'h162, 9'h165, 9'h165, 9'h166, 9'h000,
                            9'h100, 9'h000, 9'h102, 9'h000, 9'h10A, 9'h000};

  always #5 clk = ~clk;

  uart_hex_formatter dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  uart_hex_formatter #(
    .NUM_SLOTS(1), .DIGITS_PER_SLOT(4), .STR_LEN(4),
    .FORMAT_STRING({8'h01, 8'h00, 8'h02, 8'h0A}), .UPPERCASE(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .din(din2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues start in the current cycle and collects the message until done (or aborts via rst)
  task automatic run_msg(input string tag, input bit bp, input bit mid, input int abort_at);
    logic [7:0] got[$];
    logic [7:0] held;
    int n, first_v, last_acc, done_c;
    bit stall, seen_done;
    n = 0; first_v = -1; last_acc = -1; done_c = -1; stall = 0; seen_done = 0; held = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_c1"}, busy, 1);
    for (int c = 1; c < 400; c++) begin
      if (stall) begin
        chk({tag, "_stall_valid"}, out_valid, 1);
        chk({tag, "_stall_data"}, out_data, held);
      end
      if (out_valid && first_v < 0) first_v = c;
      if (done) begin
        seen_done = 1;
        done_c = c;
        break;
      end
      if (abort_at >= 0 && n == abort_at && out_valid) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({tag, "_rst_valid"}, out_valid, 0);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_done"}, done, 0);
        return;
      end
      start = mid && c == 5;
      if (mid && c == 5) din = 16'h1234;
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      stall = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        last_acc = c;
        n++;
      end
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_done_seen"}, seen_done, 1);
    chk({tag, "_first_valid"}, first_v, 2);
    chk({tag, "_done_after_last"}, done_c, last_acc + 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    if (!bp) chk({tag, "_done_cycle"}, done_c, 27);
    chk({tag, "_len"}, got.size(), msg.len());
    for (int i = 0; i < msg.len(); i++)
      if (i < got.size()) chk($sformatf("%s_b%0d", tag, i), got[i], msg[i]);
  endtask

  initial begin
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid2", out_valid2, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready_no_effect", out_valid, 0);
    run_msg("plain", 0, 0, -1);
    tick();
    run_msg("backpressure", 1, 0, -1);
    tick();
    din = 16'h3A5F;
    run_msg("mid_start", 0, 1, -1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_second_valid", out_valid, 0);
      chk("no_second_done", done, 0);
      chk("no_second_busy", busy, 0);
    end
    din = 16'h3A5F;
    run_msg("chain_a", 0, 0, -1);
    run_msg("chain_b", 0, 0, -1);
    tick();
    run_msg("abort", 0, 0, 5);
    run_msg("after_abort", 0, 0, -1);
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("d2_busy_c1", busy2, 1);
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("d2_c%0d", c), {out_valid2, out_valid2 ? out_data2 : 8'h00}, tbl2[c-1]);
      chk($sformatf("d2_done_c%0d", c), done2, c == 12);
      if (c < 12) tick();
    end
    chk("d2_busy_end", busy2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
